ysyx_22040931_fetch_queue: RTL
==============================

# ysyx_22040931_fetch_queue

Instruction fetch queue on the consumer side of the PC-stage handshake. It accepts each valid PC (with its predictor tag) from the PC generator and issues an instruction-memory read for it. Returned instructions are held in order in a small queue and presented to ID with a valid/ready handshake. On a flush it discards all queued and in-flight fetches, including responses still outstanding in memory.

## Interface
Parameters:
- DEPTH, 4, queue entries and the maximum number of outstanding memory reads (power of two, ≥2)
- PC_W, 64, PC / branch-target width
- INST_W, 32, instruction width

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc_valid  in  1  PC stage offers a PC this cycle
- if_ready  out  1  queue accepts the offered PC this cycle
- if_pc  in  PC_W  offered PC
- pre_jump  in  1  predictor taken flag for if_pc
- pre_branch  in  PC_W  predicted target for if_pc
- flush  in  1  discard everything (mispredict/redirect)
- imem_req_valid  out  1  read request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  PC_W  read address
- imem_resp_valid  in  1  read data returned (in request order)
- imem_resp_data  in  INST_W  returned instruction
- id_valid  out  1  head entry valid for ID
- id_ready  in  1  ID consumes head
- id_pc  out  PC_W  head PC
- id_inst  out  INST_W  head instruction
- id_pre_jump  out  1  head predictor flag
- id_pre_branch  out  PC_W  head predicted target

## Operation
- State: circular buffer of DEPTH entries {pc, pre_jump, pre_branch, inst, done}; head, tail, and resp pointers; count (0..DEPTH); drop_cnt (0..DEPTH).
- space = (count + drop_cnt) < DEPTH.
- imem_req_valid = pc_valid & space & ~flush; imem_req_addr = if_pc.
- if_ready = imem_req_ready & space & ~flush.
- accept = pc_valid & if_ready. An accept writes {if_pc, pre_jump, pre_branch, done=0} at tail, then tail++ and count++.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt--.
  - Otherwise it writes inst into the entry at resp and sets done=1, then resp++.
- id_valid = (count>0) & head.done & ~flush. id_* are driven directly from the head entry.
- deq = id_valid & id_ready, which advances head and decrements count.
- Enqueue and dequeue in the same cycle are legal, and count then holds.
- if_ready has no combinational path from id_ready. A slot freed by deq is usable next cycle.
- flush has priority over accept, deq, and response fill:
  - head=tail=resp=0 and count=0.
  - drop_cnt <= drop_cnt + (number of entries with done=0) − (1 if a response arrives this cycle).
  - A response in the flush cycle is therefore discarded.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and drop_cnt never underflows. A response arriving with count=0 and drop_cnt=0 is a protocol error and is ignored.

## Timing
- Reset, applied asynchronously, gives count=0, drop_cnt=0, and all pointers 0.
  - Outputs while reset is high: if_ready=0, imem_req_valid=0, id_valid=0.
  - id_pc, id_inst, id_pre_branch, and id_pre_jump are 0.
- Reset mid-operation drops all state. Responses from before reset are not tracked.
- Latency: a PC accepted in cycle T with its response in cycle T+k (k≥1) gives id_valid in cycle T+k+1 (fill is registered).
- Throughput: one PC per cycle sustained when memory latency k < DEPTH and ID is always ready.
- id_* remain stable while id_valid=1 and id_ready=0.
- The queue stops accepting at count+drop_cnt=DEPTH. if_ready rises the cycle after a deq or drop.

## Test plan
- Single fetch: PC 0x80000000 accepted in cycle 1, response 0x00000413 in cycle 2 -> cycle 3 id_valid=1, id_pc=0x80000000, id_inst=0x00000413. Dequeued with id_ready=1.
- Back-to-back stream: PCs 0x80000000..0x8000000C at 1/cycle, 1-cycle memory, id_ready=1 -> 4 instructions in order on consecutive cycles with no bubble. if_ready stays 1.
- Backpressure/full (DEPTH=4): id_ready=0, 4 PCs accepted and answered -> if_ready=0 and id_* hold the first entry. Raising id_ready drains one entry per cycle, and if_ready=1 the cycle after the first deq.
- Flush with 2 in flight: 3 accepted, 1 answered, then flush -> next cycle count=0, drop_cnt=2, id_valid=0. The next 2 responses are discarded. A new PC 0x80001000 answered after them appears with the correct instruction.
- Simultaneous flush + response: flush in the cycle a response arrives with 1 outstanding -> drop_cnt=0 afterwards and the response is never presented.
- Async reset asserted mid-stream between clock edges -> id_valid, if_ready, and imem_req_valid fall immediately. After deassertion the first new fetch behaves as in the single-fetch case.

Source files
------------

// File: rtl/ysyx_22040931_fetch_queue.sv
// ysyx_22040931_fetch_queue
//
// Instruction fetch queue between the PC generator and ID.
// Each accepted PC (with its predictor tag) is recorded at the tail of a small
// in-order queue, and the matching instruction-memory read is issued in the
// same cycle. Responses return in request order and fill entries in order.
// ID pops the head entry through a valid/ready handshake. On a flush, every
// queued entry is discarded, and responses that are still outstanding in
// memory are counted so that they can be dropped when they arrive.
//
// Ports
//   clock, reset        clock and asynchronous active-high reset
//   pc_valid/if_ready   PC-stage handshake (if_pc, pre_jump, pre_branch)
//   flush               discard all queued and in-flight fetches
//   imem_req_*          read request (valid/ready, address)
//   imem_resp_*         read response (valid, data), returned in request order
//   id_valid/id_ready   ID handshake for the head entry
//   id_pc, id_inst, id_pre_jump, id_pre_branch   head entry contents
module ysyx_22040931_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              pre_jump,
    input  logic [PC_W-1:0]   pre_branch,
    input  logic              flush,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_pre_jump,
    output logic [PC_W-1:0]   id_pre_branch
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PC_W-1:0]   pc_q   [DEPTH];
    logic              pj_q   [DEPTH];
    logic [PC_W-1:0]   pb_q   [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0]  done_q;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] resp;
    logic [CW-1:0] count;
    logic [CW-1:0] drop_cnt;
    // Live entries still waiting for their response; equals the number of
    // entries with done=0 among the queued ones.
    logic [CW-1:0] pend;

    logic [CW:0]   occ;
    logic          space;
    logic          accept;
    logic          deq;
    logic          drop;
    logic          fill;
    logic [CW-1:0] flush_drop;

    always_comb begin
        occ            = {1'b0, count} + {1'b0, drop_cnt};
        space          = occ < (CW + 1)'(DEPTH);
        if_ready       = ~reset & imem_req_ready & space & ~flush;
        imem_req_valid = ~reset & pc_valid & space & ~flush;
        imem_req_addr  = if_pc;
        id_valid       = ~reset & (count != '0) & done_q[head] & ~flush;
        accept         = pc_valid & if_ready;
        deq            = id_valid & id_ready;
        drop           = imem_resp_valid & (drop_cnt != '0);
        // pend guards against a stray response overwriting a completed entry.
        fill           = imem_resp_valid & (drop_cnt == '0) & (pend != '0);
        // A response arriving in the flush cycle belongs to the oldest
        // outstanding read, so it is consumed here instead of being counted.
        flush_drop     = drop_cnt + pend;
        if (imem_resp_valid && flush_drop != '0) begin
            flush_drop = flush_drop - CW'(1);
        end
    end

    // Head entry outputs read as zero while reset is asserted.
    always_comb begin
        id_pc         = '0;
        id_inst       = '0;
        id_pre_jump   = 1'b0;
        id_pre_branch = '0;
        if (!reset) begin
            id_pc         = pc_q[head];
            id_inst       = inst_q[head];
            id_pre_jump   = pj_q[head];
            id_pre_branch = pb_q[head];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            resp     <= '0;
            count    <= '0;
            drop_cnt <= '0;
            pend     <= '0;
            done_q   <= '0;
        end else if (flush) begin
            head     <= '0;
            tail     <= '0;
            resp     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= flush_drop;
        end else begin
            if (accept) begin
                tail         <= tail + PW'(1);
                done_q[tail] <= 1'b0;
            end
            if (fill) begin
                resp         <= resp + PW'(1);
                done_q[resp] <= 1'b1;
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            if (drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            count <= count + CW'(accept) - CW'(deq);
            pend  <= pend + CW'(accept) - CW'(fill);
        end
    end

    // Payload storage has no reset; an entry is only observed after it has
    // been written by an accept and marked done by a fill.
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            if (accept) begin
                pc_q[tail] <= if_pc;
                pj_q[tail] <= pre_jump;
                pb_q[tail] <= pre_branch;
            end
            if (fill) begin
                inst_q[resp] <= imem_resp_data;
            end
        end
    end

endmodule
